reg_select_decoder: RTL and testbench

REG_SELECT_DECODER -- requirements
Module: reg_select_decoder

---
 rtl/reg_select_decoder.sv | 154 +++++++++++++++
 tb/tb_reg_select_decoder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_select_decoder.sv
// reg_select_decoder
//
// Registered one-hot decoder with a self-timed sweep mode.
//
// In IDLE, each cycle with enable=1 produces dataOut = 1<<dataIn on the
// following cycle (all-zero otherwise). A sweepStart request walks a single
// hot bit from bit 0 up to bit N-1, holding each position for SWEEP_HOLD
// cycles, then returns to IDLE with a one-cycle sweepDone pulse. sweepAbort
// ends a sweep early without the done pulse. Every output comes straight from
// a flop, so there is no combinational path from any input to any output.
//
// Handshake: there is no valid/ready pairing here. enable, sweepStart and
// sweepAbort are level requests sampled on every rising clk edge. A request
// takes effect in the cycle after the edge that sampled it and needs no
// acknowledgement. busy reports that a sweep owns dataOut and that enable,
// dataIn and sweepStart are being ignored.
//
// Parameters
//   SEL_WIDTH  : select width, 1..8; output width N = 2**SEL_WIDTH
//   SWEEP_HOLD : cycles each one-hot position is held during a sweep, 1..255
//
// Ports
//   clk         : clock, rising-edge active
//   rst_n       : asynchronous active-low reset
//   dataIn      : select index for a single decode
//   enable      : single-decode request
//   sweepStart  : start an ascending sweep over every output bit
//   sweepAbort  : end an active sweep; also blocks a same-cycle sweepStart
//   dataOut     : registered one-hot (or all-zero) result
//   busy        : high while a sweep is in progress
//   sweepIndex  : bit index currently driven by the sweep; 0 in IDLE
//   sweepDone   : one-cycle pulse when a sweep completes normally
//   dbg_state_o : current FSM state (0 = IDLE, 1 = SWEEP) for observation
module reg_select_decoder #(
  parameter int SEL_WIDTH  = 5,
  parameter int SWEEP_HOLD = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [SEL_WIDTH-1:0]      dataIn,
  input  logic                      enable,
  input  logic                      sweepStart,
  input  logic                      sweepAbort,
  output logic [2**SEL_WIDTH-1:0]   dataOut,
  output logic                      busy,
  output logic [SEL_WIDTH-1:0]      sweepIndex,
  output logic                      sweepDone,
  output logic                      dbg_state_o
);

  localparam int N = 2**SEL_WIDTH;

  // The counter only needs to reach SWEEP_HOLD-1, so it fits in
  // clog2(SWEEP_HOLD) bits. One bit is kept when SWEEP_HOLD=1 so that the
  // vector still exists; in that case the counter stays at 0.
  localparam int HW = (SWEEP_HOLD > 1) ? $clog2(SWEEP_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(SWEEP_HOLD - 1);
  localparam logic [N-1:0]  ONE       = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [N-1:0]           data_q, data_d;
  logic [SEL_WIDTH-1:0]   idx_q, idx_d;
  logic [HW-1:0]          hold_q, hold_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  always_comb begin
    state_d = state_q;
    data_d  = '0;
    idx_d   = idx_q;
    hold_d  = hold_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        idx_d  = '0;
        hold_d = '0;
        busy_d = 1'b0;
        // sweepStart has priority over enable. A same-cycle sweepAbort
        // cancels the start, and the enable is then still honoured.
        if (sweepStart && !sweepAbort) begin
          state_d = ST_SWEEP;
          data_d  = ONE;
          busy_d  = 1'b1;
        end else if (enable) begin
          data_d = ONE << dataIn;
        end
      end

      ST_SWEEP: begin
        if (sweepAbort) begin
          state_d = ST_IDLE;
          idx_d   = '0;
          hold_d  = '0;
          busy_d  = 1'b0;
        end else if (hold_q == HOLD_LAST) begin
          hold_d = '0;
          if (&idx_q) begin
            // The last index has been held long enough. Finish without
            // wrapping back to bit 0.
            state_d = ST_IDLE;
            idx_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d  = idx_q + 1'b1;
            data_d = data_q << 1;
          end
        end else begin
          hold_d = hold_q + 1'b1;
          data_d = data_q;
        end
      end

      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
        hold_d  = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      idx_q   <= '0;
      hold_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign dataOut     = data_q;
  assign busy        = busy_q;
  assign sweepIndex  = idx_q;
  assign sweepDone   = done_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_reg_select_decoder.sv
// Bench for reg_select_decoder. Two instances share one set of inputs:
// u_h2 uses SWEEP_HOLD=2 and u_h1 uses SWEEP_HOLD=1, both with SEL_WIDTH=5.
// A timeline reference model tracks each instance. It counts the cycles since
// the sweep started and derives the hot bit arithmetically. Table vectors and
// hand-written sequences add fixed expected values on top of the model.
module tb_reg_select_decoder;

  logic        clk;
  logic        rst_n;
  logic [4:0]  din;
  logic        en, st, ab;

  logic [31:0] dout [2];
  logic        busy_o [2];
  logic [4:0]  sidx [2];
  logic        sdone [2];
  logic        dbg [2];

  int n_tests = 0;
  int n_fail  = 0;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  reg_select_decoder #(.SEL_WIDTH(5), .SWEEP_HOLD(2)) u_h2 (
    .clk(clk), .rst_n(rst_n), .dataIn(din), .enable(en),
    .sweepStart(st), .sweepAbort(ab), .dataOut(dout[0]), .busy(busy_o[0]),
    .sweepIndex(sidx[0]), .sweepDone(sdone[0]), .dbg_state_o(dbg[0])
  );

  reg_select_decoder #(.SEL_WIDTH(5), .SWEEP_HOLD(1)) u_h1 (
    .clk(clk), .rst_n(rst_n), .dataIn(din), .enable(en),
    .sweepStart(st), .sweepAbort(ab), .dataOut(dout[1]), .busy(busy_o[1]),
    .sweepIndex(sidx[1]), .sweepDone(sdone[1]), .dbg_state_o(dbg[1])
  );

  // reference model: m_el = cycles since the sampled sweepStart (1 = first)
  bit          m_sw [2];
  int          m_el [2];
  logic [31:0] e_data [2];
  logic        e_busy [2];
  logic [4:0]  e_idx [2];
  logic        e_done [2];

  function automatic logic [39:0] pk(logic [31:0] d, logic b, logic [4:0] i,
                                     logic dn, logic s);
    return {d, b, i, dn, s};
  endfunction

  task automatic model_clear(input int d);
    m_sw[d] = 0; m_el[d] = 0;
    e_data[d] = '0; e_busy[d] = 1'b0; e_idx[d] = '0; e_done[d] = 1'b0;
  endtask

  task automatic model_step(input int d, input int hold);
    int k;
    e_done[d] = 1'b0;
    if (!rst_n) begin
      model_clear(d);
    end else if (m_sw[d]) begin
      if (ab) begin
        model_clear(d);
      end else begin
        m_el[d]++;
        if (m_el[d] > 32 * hold) begin
          model_clear(d);
          e_done[d] = 1'b1;
        end else begin
          k = (m_el[d] - 1) / hold;
          e_data[d] = 32'h1 << k;
          e_idx[d]  = 5'(k);
          e_busy[d] = 1'b1;
        end
      end
    end else if (st && !ab) begin
      m_sw[d] = 1; m_el[d] = 1;
      e_data[d] = 32'h1; e_idx[d] = '0; e_busy[d] = 1'b1;
    end else begin
      e_data[d] = en ? (32'h1 << din) : 32'h0;
      e_busy[d] = 1'b0;
      e_idx[d]  = '0;
    end
  endtask

  // scoreboard
  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got data=%h busy=%b idx=%0d done=%b st=%b, expected data=%h busy=%b idx=%0d done=%b st=%b",
               name, $time, act[39:8], act[7], act[6:2], act[1], act[0],
               exp[39:8], exp[7], exp[6:2], exp[1], exp[0]);
    end
  endtask

  task automatic chk_model();
    chk("model_h2", pk(dout[0], busy_o[0], sidx[0], sdone[0], dbg[0]),
        pk(e_data[0], e_busy[0], e_idx[0], e_done[0], m_sw[0]));
    chk("model_h1", pk(dout[1], busy_o[1], sidx[1], sdone[1], dbg[1]),
        pk(e_data[1], e_busy[1], e_idx[1], e_done[1], m_sw[1]));
  endtask

  // fixed expectation; FSM state is expected to track busy
  task automatic hchk(input string name, input int d, input logic [31:0] xd,
                      input logic xb, input logic [4:0] xi, input logic xdn);
    chk(name, pk(dout[d], busy_o[d], sidx[d], sdone[d], dbg[d]), pk(xd, xb, xi, xdn, xb));
  endtask

  // driver
  task automatic tick();
    @(posedge clk);
    model_step(0, 2);
    model_step(1, 1);
    #1;
    chk_model();
  endtask

  task automatic drive(input logic e, input logic [4:0] d, input logic s, input logic a);
    en = e; din = d; st = s; ab = a;
    tick();
  endtask

  typedef struct {
    logic        e;
    logic [4:0]  d;
    logic        s;
    logic        a;
    logic [31:0] x_data;
  } vec_t;

  vec_t vt[9];

  initial begin
    vt[0] = '{1'b1, 5'd31, 1'b0, 1'b0, 32'h8000_0000};
    vt[1] = '{1'b0, 5'd31, 1'b0, 1'b0, 32'h0};
    vt[2] = '{1'b1, 5'd0,  1'b0, 1'b0, 32'h1};
    vt[3] = '{1'b1, 5'd3,  1'b0, 1'b0, 32'h8};
    vt[4] = '{1'b1, 5'd4,  1'b0, 1'b0, 32'h10};
    vt[5] = '{1'b0, 5'd4,  1'b0, 1'b0, 32'h0};
    vt[6] = '{1'b1, 5'd7,  1'b1, 1'b1, 32'h80};
    vt[7] = '{1'b0, 5'd0,  1'b1, 1'b1, 32'h0};
    vt[8] = '{1'b1, 5'd12, 1'b0, 1'b1, 32'h1000};

    rst_n = 1'b0; en = 0; din = '0; st = 0; ab = 0;
    model_clear(0); model_clear(1);
    #12;
    hchk("reset_h2", 0, 32'h0, 1'b0, 5'd0, 1'b0);
    hchk("reset_h1", 1, 32'h0, 1'b0, 5'd0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // table: single decodes in IDLE, including start+abort collisions
    foreach (vt[i]) begin
      drive(vt[i].e, vt[i].d, vt[i].s, vt[i].a);
      hchk($sformatf("vec%0d_h2", i), 0, vt[i].x_data, 1'b0, 5'd0, 1'b0);
      hchk($sformatf("vec%0d_h1", i), 1, vt[i].x_data, 1'b0, 5'd0, 1'b0);
    end

    // full sweep; enable/dataIn=7 in the start cycle must not decode
    drive(1'b1, 5'd7, 1'b1, 1'b0);                     // now cycle 1
    hchk("sweep_c1_h2", 0, 32'h1, 1'b1, 5'd0, 1'b0);
    hchk("sweep_c1_h1", 1, 32'h1, 1'b1, 5'd0, 1'b0);
    for (int c = 2; c <= 65; c++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
            (c <= 32) ? 1'($urandom_range(0, 1)) : 1'b0, 1'b0);
      if (c <= 64)
        hchk("sweep_h2", 0, 32'h1 << ((c - 1) / 2), 1'b1, 5'((c - 1) / 2), 1'b0);
      else
        hchk("sweep_done_h2", 0, 32'h0, 1'b0, 5'd0, 1'b1);
      if (c <= 32)
        hchk("sweep_h1", 1, 32'h1 << (c - 1), 1'b1, 5'(c - 1), 1'b0);
      else if (c == 33)
        hchk("sweep_done_h1", 1, 32'h0, 1'b0, 5'd0, 1'b1);
    end
    drive(1'b1, 5'd5, 1'b0, 1'b0);                     // first IDLE cycle samples
    hchk("after_done_h2", 0, 32'h20, 1'b0, 5'd0, 1'b0);

    // abort while index 5 is driven (cycles 11-12 with hold 2)
    drive(1'b0, 5'd0, 1'b1, 1'b0);
    for (int c = 2; c <= 11; c++) drive(1'b0, 5'd0, 1'b0, 1'b0);
    hchk("idx5_h2", 0, 32'h20, 1'b1, 5'd5, 1'b0);
    drive(1'b0, 5'd0, 1'b0, 1'b1);
    hchk("abort_idx5_h2", 0, 32'h0, 1'b0, 5'd0, 1'b0);
    drive(1'b0, 5'd0, 1'b1, 1'b1);
    hchk("start_abort_idle_h2", 0, 32'h0, 1'b0, 5'd0, 1'b0);

    // abort sampled in the final hold cycle: no done pulse
    drive(1'b0, 5'd0, 1'b1, 1'b0);
    for (int c = 2; c <= 64; c++) drive(1'b0, 5'd0, 1'b0, 1'b0);
    hchk("last_hold_h2", 0, 32'h8000_0000, 1'b1, 5'd31, 1'b0);
    drive(1'b0, 5'd0, 1'b0, 1'b1);
    hchk("abort_last_h2", 0, 32'h0, 1'b0, 5'd0, 1'b0);
    drive(1'b0, 5'd0, 1'b0, 1'b0);
    hchk("abort_last_nodone_h2", 0, 32'h0, 1'b0, 5'd0, 1'b0);

    // asynchronous reset at index 9, between clock edges
    drive(1'b0, 5'd0, 1'b1, 1'b0);
    for (int c = 2; c <= 19; c++) drive(1'b0, 5'd0, 1'b0, 1'b0);
    hchk("idx9_h2", 0, 32'h200, 1'b1, 5'd9, 1'b0);
    #2;
    rst_n = 1'b0;
    model_clear(0); model_clear(1);
    #1;
    hchk("async_rst_h2", 0, 32'h0, 1'b0, 5'd0, 1'b0);
    hchk("async_rst_h1", 1, 32'h0, 1'b0, 5'd0, 1'b0);
    for (int c = 0; c < 3; c++) drive(1'b1, 5'd3, 1'b1, 1'b0);
    hchk("in_rst_nodone_h2", 0, 32'h0, 1'b0, 5'd0, 1'b0);
    rst_n = 1'b1;
    drive(1'b1, 5'd9, 1'b0, 1'b0);
    hchk("post_rst_h2", 0, 32'h200, 1'b0, 5'd0, 1'b0);
    hchk("post_rst_h1", 1, 32'h200, 1'b0, 5'd0, 1'b0);

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
            ($urandom_range(0, 15) == 0), ($urandom_range(0, 39) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
